// File: rtl/mouse_packet_tracker.sv
// PS/2 movement packet assembler: decodes validated mouse bytes into clamped X/Y, wheel Z and a commit pulse.
// Define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets; without it packets are 3 bytes and MouseZ stays 0.
module mouse_packet_tracker #(
  parameter int MOUSE_LIMIT_X = 160,
  parameter int MOUSE_LIMIT_Y = 120,
  parameter int PKT_TIMEOUT   = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       STREAM_EN,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  output logic [3:0] MouseStatus,
  output logic [7:0] MouseX,
  output logic [7:0] MouseY,
  output logic [7:0] MouseZ,
  output logic       SendInterrupt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] B1     = 3'd1;
  localparam logic [2:0] B2     = 3'd2;
`ifdef MOUSE_WHEEL_EN
  localparam logic [2:0] B3     = 3'd3;
`endif
  localparam logic [2:0] COMMIT = 3'd4;

  localparam int TW = (PKT_TIMEOUT > 1) ? $clog2(PKT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PKT_TIMEOUT - 1);

  localparam logic [7:0] X_HOME = 8'(MOUSE_LIMIT_X / 2);
  localparam logic [7:0] Y_HOME = 8'(MOUSE_LIMIT_Y / 2);
  localparam logic signed [10:0] X_MAX = 11'(MOUSE_LIMIT_X - 1);
  localparam logic signed [10:0] Y_MAX = 11'(MOUSE_LIMIT_Y - 1);

  // Status byte minus the sync bit, which only matters while hunting for a packet start.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic m;
    logic r;
    logic l;
  } status_t;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  status_t       status_q;
  logic [7:0]    dx_q;
  logic [7:0]    dy_q;
`ifdef MOUSE_WHEEL_EN
  logic [7:0]    dz_q;
`endif

  logic byte_ok;
  logic byte_bad;
  logic in_packet;

  logic signed [10:0] dx_ext;
  logic signed [10:0] dy_ext;
  logic signed [10:0] x_sum;
  logic signed [10:0] y_sum;
  logic [7:0]         x_next;
  logic [7:0]         y_next;

  assign byte_ok  = BYTE_VALID & ~BYTE_ERROR;
  assign byte_bad = BYTE_VALID & BYTE_ERROR;
`ifdef MOUSE_WHEEL_EN
  assign in_packet = (state == B1) || (state == B2) || (state == B3);
`else
  assign in_packet = (state == B1) || (state == B2);
`endif

  // Overflow saturates to +/-255; PS/2 Y is up-positive, the screen is down-positive.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dx_ext = status_q.x_ovf ? (status_q.x_sign ? -11'sd255 : 11'sd255)
                            : $signed({{3{status_q.x_sign}}, dx_q});
    dy_ext = status_q.y_ovf ? (status_q.y_sign ? -11'sd255 : 11'sd255)
                            : $signed({{3{status_q.y_sign}}, dy_q});
    x_sum  = $signed({3'b000, MouseX}) + dx_ext;
    y_sum  = $signed({3'b000, MouseY}) - dy_ext;
    x_next = x_sum[7:0];
    y_next = y_sum[7:0];
    if (x_sum < 0)          x_next = '0;
    else if (x_sum > X_MAX) x_next = X_MAX[7:0];
    if (y_sum < 0)          y_next = '0;
    else if (y_sum > Y_MAX) y_next = Y_MAX[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      timer         <= '0;
      status_q      <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      MouseX        <= X_HOME;
      MouseY        <= Y_HOME;
      MouseStatus   <= '0;
      SendInterrupt <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      dz_q          <= '0;
      MouseZ        <= '0;
`endif
    end else begin
      SendInterrupt <= 1'b0;
      if (!STREAM_EN) begin
        state <= IDLE;
        timer <= '0;
      end else if (in_packet && (byte_bad || (!BYTE_VALID && timer == TIMER_LAST))) begin
        // Corrupt byte or stalled packet: drop the partial packet, outputs untouched.
        state <= IDLE;
        timer <= '0;
      end else begin
        if (in_packet) timer <= BYTE_VALID ? '0 : timer + TW'(1);
        else           timer <= '0;
        case (state)
          IDLE: begin
            if (byte_ok && BYTE_IN[3]) begin
              status_q <= {BYTE_IN[7:4], BYTE_IN[2:0]};
              state    <= B1;
            end
          end
          B1: begin
            if (byte_ok) begin
              dx_q  <= BYTE_IN;
              state <= B2;
            end
          end
          B2: begin
            if (byte_ok) begin
              dy_q  <= BYTE_IN;
`ifdef MOUSE_WHEEL_EN
              state <= B3;
`else
              state <= COMMIT;
`endif
            end
          end
`ifdef MOUSE_WHEEL_EN
          B3: begin
            if (byte_ok) begin
              dz_q  <= BYTE_IN;
              state <= COMMIT;
            end
          end
`endif
          COMMIT: begin
            MouseX        <= x_next;
            MouseY        <= y_next;
            MouseStatus   <= {status_q.x_ovf | status_q.y_ovf, status_q.m, status_q.r, status_q.l};
            SendInterrupt <= 1'b1;
`ifdef MOUSE_WHEEL_EN
            MouseZ        <= MouseZ + dz_q;
`endif
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef MOUSE_WHEEL_EN
  assign MouseZ = '0;
`endif

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Scoreboard bench for mouse_packet_tracker: directed packets plus randomized packets and abort cases.
module tb_mouse_packet_tracker;

  localparam int LX = 160;
  localparam int LY = 120;
  localparam int TO = 32;
`ifdef MOUSE_WHEEL_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       STREAM_EN;
  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic       BYTE_ERROR;
  logic [3:0] MouseStatus;
  logic [7:0] MouseX;
  logic [7:0] MouseY;
  logic [7:0] MouseZ;
  logic       SendInterrupt;

  mouse_packet_tracker #(
    .MOUSE_LIMIT_X(LX),
    .MOUSE_LIMIT_Y(LY),
    .PKT_TIMEOUT  (TO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .STREAM_EN    (STREAM_EN),
    .BYTE_IN      (BYTE_IN),
    .BYTE_VALID   (BYTE_VALID),
    .BYTE_ERROR   (BYTE_ERROR),
    .MouseStatus  (MouseStatus),
    .MouseX       (MouseX),
    .MouseY       (MouseY),
    .MouseZ       (MouseZ),
    .SendInterrupt(SendInterrupt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x;
    int y;
    int z;
    int st;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  int   n_irq    = 0;

  // Packet-level reference model state.
  int mx = LX / 2;
  int my = LY / 2;
  int mz = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(input logic ovf, input logic sign, input logic [7:0] b);
    if (ovf) return sign ? -255 : 255;
    return sign ? int'(b) - 256 : int'(b);
  endfunction

  // Monitor: pops an expectation on every interrupt; otherwise outputs must hold.
  int cur_x = LX / 2;
  int cur_y = LY / 2;
  int cur_z = 0;
  int cur_st = 0;
  always @(negedge CLK) begin
    if (RESET) begin
      cur_x  = LX / 2;
      cur_y  = LY / 2;
      cur_z  = 0;
      cur_st = 0;
    end else begin
      if (SendInterrupt) begin
        n_irq++;
        if (exp_q.size() == 0) begin
          check("unexpected_interrupt", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_latency", edge_cnt, e.cyc);
          cur_x  = e.x;
          cur_y  = e.y;
          cur_z  = e.z;
          cur_st = e.st;
        end
      end
      check("MouseX", int'(MouseX), cur_x);
      check("MouseY", int'(MouseY), cur_y);
      check("MouseZ", int'(MouseZ), cur_z);
      check("MouseStatus", int'(MouseStatus), cur_st);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic err, output int drv_cyc);
    @(negedge CLK);
    BYTE_IN    = b;
    BYTE_ERROR = err;
    BYTE_VALID = 1'b1;
    drv_cyc    = edge_cnt;
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    BYTE_ERROR = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int drv_cyc);
    exp_t e;
    mx = clamp(mx + delta(b0[6], b0[4], b1), LX - 1);
    my = clamp(my - delta(b0[7], b0[5], b2), LY - 1);
`ifdef MOUSE_WHEEL_EN
    mz = (mz + (b3[7] ? int'(b3) - 256 : int'(b3)) + 256) % 256;
`else
    if (b3 != b3) mz = 0;
`endif
    e.x   = mx;
    e.y   = my;
    e.z   = mz;
    e.st  = {(b0[6] | b0[7]) ? 1 : 0, int'(b0[2:0])} ;
    e.st  = ((b0[6] | b0[7]) ? 8 : 0) + int'(b0[2:0]);
    e.cyc = drv_cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int gap);
    logic [7:0] pk[4];
    int c;
    pk[0] = b0; pk[1] = b1; pk[2] = b2; pk[3] = b3;
    for (int i = 0; i < PKT_LEN; i++) begin
      drive_byte(pk[i], 1'b0, c);
      if (i < PKT_LEN - 1) idle(gap);
    end
    model_commit(b0, b1, b2, b3, c);
  endtask

  // Drives the first k bytes of a packet without completing it.
  task automatic send_partial(input int k);
    int c;
    drive_byte(8'h08 | 8'($urandom_range(0, 255)), 1'b0, c);
    for (int i = 1; i < k; i++) drive_byte(8'($urandom), 1'b0, c);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    mx = LX / 2;
    my = LY / 2;
    mz = 0;
  endtask

  function automatic logic [7:0] rand_status();
    logic [7:0] s;
    s = 8'($urandom);
    s[3] = 1'b1;
    if ($urandom_range(0, 7) != 0) s[7:6] = 2'b00;
    return s;
  endfunction

  initial begin
    int exp_x[6];
    int c;
    RESET      = 1'b1;
    STREAM_EN  = 1'b0;
    BYTE_IN    = '0;
    BYTE_VALID = 1'b0;
    BYTE_ERROR = 1'b0;
    idle(3);
    RESET = 1'b0;
    @(negedge CLK);
    check("reset_x", int'(MouseX), 80);
    check("reset_y", int'(MouseY), 60);
    check("reset_z", int'(MouseZ), 0);
    check("reset_status", int'(MouseStatus), 0);
    check("reset_irq", int'(SendInterrupt), 0);
    STREAM_EN = 1'b1;

    send_pkt(8'h08, 8'h05, 8'h03, 8'h00, 1);
    idle(3);
    check("basic_x", int'(MouseX), 85);
    check("basic_y", int'(MouseY), 57);
    check("basic_irq_count", n_irq, 1);

    do_reset();
    exp_x = '{64, 48, 32, 16, 0, 0};
    for (int i = 0; i < 6; i++) begin
      send_pkt(8'h18, 8'hF0, 8'h00, 8'h00, 0);
      idle(3);
      check("neg_clamp_x", int'(MouseX), exp_x[i]);
    end
    check("neg_clamp_irq_count", n_irq, 7);

    send_pkt(8'h49, 8'h00, 8'h00, 8'h00, 1);
    idle(3);
    check("xovf_x", int'(MouseX), 159);
    check("xovf_status", int'(MouseStatus), 9);
    send_pkt(8'hA8, 8'h00, 8'h00, 8'h00, 1);
    idle(3);
    check("yovf_y", int'(MouseY), 119);

    do_reset();
    drive_byte(8'h05, 1'b0, c);
    send_pkt(8'h08, 8'h01, 8'h01, 8'h00, 1);
    idle(3);
    check("resync_x", int'(MouseX), 81);
    check("resync_y", int'(MouseY), 59);
    check("resync_irq_count", n_irq, 10);

    drive_byte(8'h08, 1'b0, c);
    drive_byte(8'h05, 1'b0, c);
    drive_byte(8'h00, 1'b1, c);
    idle(3);
    check("err_abort_hold_x", int'(MouseX), 81);
    send_pkt(8'h08, 8'h05, 8'h03, 8'h00, 1);
    idle(3);
    check("after_err_x", int'(MouseX), 86);
    check("after_err_y", int'(MouseY), 56);

`ifdef MOUSE_WHEEL_EN
    do_reset();
    send_pkt(8'h08, 8'h00, 8'h00, 8'hFF, 1);
    send_pkt(8'h08, 8'h00, 8'h00, 8'hFF, 1);
    idle(3);
    check("wheel_z", int'(MouseZ), 8'hFE);
    do_reset();
    for (int i = 0; i < 2; i++) send_pkt(8'h08, 8'h00, 8'h00, 8'h40, 0);
    send_pkt(8'h08, 8'h00, 8'h00, 8'h3F, 0);
    send_pkt(8'h08, 8'h00, 8'h00, 8'h01, 0);
    idle(3);
    check("wheel_wrap_z", int'(MouseZ), 8'h80);
`endif

    // Randomized mix of good packets and every abort path.
    for (int it = 0; it < 250; it++) begin
      int sel;
      int k;
      sel = $urandom_range(0, 11);
      k   = $urandom_range(1, PKT_LEN - 1);
      case (sel)
        5: begin
          drive_byte(8'($urandom) & 8'hF7, 1'b0, c);
          send_pkt(rand_status(), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4));
        end
        6: begin
          send_partial(k);
          drive_byte(8'($urandom), 1'b1, c);
        end
        7: begin
          send_partial(k);
          @(negedge CLK);
          STREAM_EN = 1'b0;
          for (int i = 0; i < PKT_LEN; i++) drive_byte(8'h08, 1'b0, c);
          STREAM_EN = 1'b1;
        end
        8: begin
          send_partial(k);
          idle(TO + 3);
        end
        9: begin
          send_partial(k);
          do_reset();
        end
        10: send_pkt(rand_status(), 8'($urandom), 8'($urandom), 8'($urandom), TO - 4);
        default:
          send_pkt(rand_status(), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4));
      endcase
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
